// File: rtl/gt_hs_pkg.sv
// Shared math-components constants: default operand width and the
// handshake FSM state encoding used by the compare blocks.
package gt_hs_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        GET_A   = 2'd0,
        GET_B   = 2'd1,
        COMPARE = 2'd2,
        PUT_Z   = 2'd3
    } state_t;

endpackage

// File: rtl/gt_hs_core.sv
// Combinational signed greater-than, shared by the handshake compare blocks.
module gt_core
    import gt_hs_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             z
);

    always_comb begin
        z = ($signed(a) > $signed(b));
    end

endmodule

// File: rtl/gt_hs.sv
// Handshaked signed A > B: take A, take B, compare, then hold the result
// until the consumer acknowledges it.
module gt_hs
    import gt_hs_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_a,
    input  logic             input_a_stb,
    output logic             input_a_ack,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_b_stb,
    output logic             input_b_ack,
    output logic             output_z,
    output logic             output_z_stb,
    input  logic             output_z_ack
);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             a_ack_next, b_ack_next, z_next, z_stb_next;
    logic             core_z;

    gt_core #(.WIDTH(WIDTH)) u_core (
        .a (a_reg),
        .b (b_reg),
        .z (core_z)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= GET_A;
            a_reg        <= '0;
            b_reg        <= '0;
            input_a_ack  <= 1'b1;
            input_b_ack  <= 1'b0;
            output_z     <= 1'b0;
            output_z_stb <= 1'b0;
        end else begin
            state        <= state_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            input_a_ack  <= a_ack_next;
            input_b_ack  <= b_ack_next;
            output_z     <= z_next;
            output_z_stb <= z_stb_next;
        end
    end

    // Ack/stb outputs are registered, so their next values are decided here
    // alongside the state transition that makes them true.
    always_comb begin
        state_next = state;
        a_next     = a_reg;
        b_next     = b_reg;
        a_ack_next = input_a_ack;
        b_ack_next = input_b_ack;
        z_next     = output_z;
        z_stb_next = output_z_stb;
        unique case (state)
            GET_A: begin
                if (input_a_ack && input_a_stb) begin
                    a_next     = input_a;
                    a_ack_next = 1'b0;
                    b_ack_next = 1'b1;
                    state_next = GET_B;
                end
            end
            GET_B: begin
                if (input_b_ack && input_b_stb) begin
                    b_next     = input_b;
                    b_ack_next = 1'b0;
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                z_next     = core_z;
                z_stb_next = 1'b1;
                state_next = PUT_Z;
            end
            PUT_Z: begin
                if (output_z_stb && output_z_ack) begin
                    z_stb_next = 1'b0;
                    a_ack_next = 1'b1;
                    state_next = GET_A;
                end
            end
            default: state_next = GET_A;
        endcase
    end

endmodule

// File: tb/tb_gt_hs.sv
// Directed and randomized checks of the handshaked signed compare block.
module tb_gt_hs;

    logic        clk;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] input_b;
    logic        input_b_stb;
    logic        input_b_ack;
    logic        output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int checks = 0;
    int errors = 0;

    gt_hs #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drives one A then one B transfer; returns once B has been taken.
    task automatic feed_ab(input logic [31:0] a, input logic [31:0] b,
                           input int gap, output bit timeout);
        int n;
        timeout = 1'b0;
        input_a = a;
        input_a_stb = 1'b1;
        n = 0;
        while (!input_a_ack && n < 50) begin
            tick();
            n++;
        end
        if (!input_a_ack) timeout = 1'b1;
        tick();
        input_a_stb = 1'b0;
        input_a = 32'hDEAD_BEEF;
        repeat (gap) tick();
        input_b = b;
        input_b_stb = 1'b1;
        n = 0;
        while (!input_b_ack && n < 50) begin
            tick();
            n++;
        end
        if (!input_b_ack) timeout = 1'b1;
        tick();
        input_b_stb = 1'b0;
        input_b = 32'hDEAD_BEEF;
    endtask

    // Waits for a result, holds ack low for gap cycles, then takes it.
    task automatic collect_z(input int gap, output logic z, output bit timeout);
        int n;
        timeout = 1'b0;
        n = 0;
        while (!output_z_stb && n < 50) begin
            tick();
            n++;
        end
        if (!output_z_stb) timeout = 1'b1;
        z = output_z;
        repeat (gap) tick();
        output_z_ack = 1'b1;
        tick();
        output_z_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({input_a_ack, input_b_ack, output_z_stb, output_z} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_outputs got a_ack,b_ack,z_stb,z=%b expected 1000",
                     {input_a_ack, input_b_ack, output_z_stb, output_z});
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int first;
        int last;
        do_reset();
        input_a = 32'd5;
        input_b = 32'd3;
        input_a_stb = 1'b1;
        input_b_stb = 1'b1;
        output_z_ack = 1'b1;
        pulses = 0;
        first = -1;
        last = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (output_z_stb) begin
                pulses++;
                if (first < 0) first = i;
                checks++;
                if (output_z !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_z cycle %0d got %b expected 1", i, output_z);
                end
                checks++;
                if (last >= 0 && i - last != 4) begin
                    errors++;
                    $display("FAIL b2b_spacing got %0d expected 4", i - last);
                end
                last = i;
            end
        end
        input_a_stb = 1'b0;
        input_b_stb = 1'b0;
        output_z_ack = 1'b0;
        checks++;
        if (pulses != 3 || first != 3) begin
            errors++;
            $display("FAIL b2b_count got pulses=%0d first=%0d expected pulses=3 first=3",
                     pulses, first);
        end
        tick();
    endtask

    task automatic test_signed();
        logic [31:0] av [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd7};
        logic [31:0] bv [3] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'd7};
        logic z;
        bit to1, to2;
        for (int i = 0; i < 3; i++) begin
            feed_ab(av[i], bv[i], 0, to1);
            collect_z(0, z, to2);
            checks++;
            if (to1 || to2 || z !== 1'b0) begin
                errors++;
                $display("FAIL signed_%0d a=%h b=%h got z=%b timeout=%0d expected z=0",
                         i, av[i], bv[i], z, to1 | to2);
            end
        end
    endtask

    task automatic test_stall();
        bit to;
        int n;
        feed_ab(32'd10, 32'd2, 1, to);
        n = 0;
        while (!output_z_stb && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (to || !output_z_stb) begin
            errors++;
            $display("FAIL stall_start got z_stb=%b timeout=%0d expected z_stb=1", output_z_stb, to);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({output_z_stb, output_z, input_a_ack, input_b_ack} !== 4'b1100) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got z_stb,z,a_ack,b_ack=%b expected 1100",
                         i, {output_z_stb, output_z, input_a_ack, input_b_ack});
            end
            tick();
        end
        output_z_ack = 1'b1;
        tick();
        output_z_ack = 1'b0;
        checks++;
        if ({output_z_stb, input_a_ack} !== 2'b01) begin
            errors++;
            $display("FAIL stall_release got z_stb,a_ack=%b expected 01", {output_z_stb, input_a_ack});
        end
    endtask

    task automatic test_early_b();
        logic z;
        bit to1, to2;
        input_b = 32'd9;
        input_b_stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({input_a_ack, input_b_ack} !== 2'b10) begin
                errors++;
                $display("FAIL early_b_ignored got a_ack,b_ack=%b expected 10", {input_a_ack, input_b_ack});
            end
        end
        input_b_stb = 1'b0;
        feed_ab(32'd4, 32'd1, 2, to1);
        collect_z(1, z, to2);
        checks++;
        if (to1 || to2 || z !== 1'b1) begin
            errors++;
            $display("FAIL early_b_result got z=%b timeout=%0d expected 1", z, to1 | to2);
        end
    endtask

    task automatic test_reset_mid();
        logic z;
        bit to1, to2;
        int n;
        feed_ab(32'd6, 32'd1, 0, to1);
        n = 0;
        while (!output_z_stb && n < 50) begin
            tick();
            n++;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({input_a_ack, input_b_ack, output_z_stb, output_z} !== 4'b1000) begin
            errors++;
            $display("FAIL async_reset got a_ack,b_ack,z_stb,z=%b expected 1000",
                     {input_a_ack, input_b_ack, output_z_stb, output_z});
        end
        tick();
        rst = 1'b0;
        output_z_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (output_z_stb !== 1'b0) begin
                errors++;
                $display("FAIL reset_discard got z_stb=%b expected 0", output_z_stb);
            end
        end
        output_z_ack = 1'b0;
        feed_ab(32'd1, 32'd2, 0, to1);
        collect_z(0, z, to2);
        checks++;
        if (to1 || to2 || z !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_pair got z=%b timeout=%0d expected 0", z, to1 | to2);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic z, exp_z;
        bit to1, to2;
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            a = $urandom();
            b = $urandom();
            if (i % 17 == 0) a = 32'h8000_0000;
            if (i % 23 == 0) b = 32'h7FFF_FFFF;
            if (i % 29 == 0) b = a;
            exp_z = ($signed(a) > $signed(b));
            repeat ($urandom_range(0, 2)) tick();
            feed_ab(a, b, $urandom_range(0, 3), to1);
            collect_z($urandom_range(0, 3), z, to2);
            checks++;
            if (to1 || to2 || z !== exp_z || output_z_stb !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_%0d a=%h b=%h got z=%b z_stb_after=%b timeout=%0d expected z=%b",
                             i, a, b, z, output_z_stb, to1 | to2, exp_z);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        input_a = '0;
        input_b = '0;
        input_a_stb = 1'b0;
        input_b_stb = 1'b0;
        output_z_ack = 1'b0;
        test_reset();
        test_back_to_back();
        do_reset();
        test_signed();
        test_stall();
        test_early_b();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
